// File: rtl/decim_pkg.sv
// Shared types and defaults for the polyphase decimator controller.
// Optional output saturation is selected by the DECIM_SAT_OUT_EN macro.
package decim_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int NPH_DEF = 4;
  localparam int DW_DEF  = 8;
  localparam int BW_DEF  = 17;
  localparam int LAT_DEF = 4;

  // Full-precision width of a sum of nph signed bw-bit terms.
  function automatic int sum_w(input int nph, input int bw);
    return bw + $clog2(nph);
  endfunction

endpackage

// File: rtl/decim_branch_sum.sv
// Combinational signed sum of all branch results; saturates to BW bits
// when DECIM_SAT_OUT_EN is defined, otherwise emits full precision.
module decim_branch_sum
  import decim_pkg::*;
#(
  parameter int NPH = NPH_DEF,
  parameter int BW  = BW_DEF,
  parameter int OW  = sum_w(NPH_DEF, BW_DEF)
) (
  input  logic [NPH*BW-1:0]   br_i,
  output logic signed [OW-1:0] sum_o
);

  localparam int SW = sum_w(NPH, BW);

  logic signed [SW-1:0] acc;
  logic signed [BW-1:0] term;

  // SW bits cannot overflow for NPH terms, so a plain accumulation is exact.
  always_comb begin
    acc  = '0;
    term = '0;
    for (int k = 0; k < NPH; k++) begin
      term = br_i[k*BW +: BW];
      acc  = acc + SW'(term);
    end
  end

`ifdef DECIM_SAT_OUT_EN
  logic signed [SW-1:0] max_v;
  logic signed [SW-1:0] min_v;

  assign max_v = {{(SW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  assign min_v = {{(SW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  always_comb begin
    if (acc > max_v)      sum_o = {1'b0, {(BW-1){1'b1}}};
    else if (acc < min_v) sum_o = {1'b1, {(BW-1){1'b0}}};
    else                  sum_o = acc[OW-1:0];
  end
`else
  assign sum_o = acc;
`endif

endmodule

// File: rtl/decim_polyphase_ctrl.sv
// Polyphase decimator commutator/controller: loads NPH samples into branch
// slices, waits LAT cycles, then holds the branch sum. See DECIM_SAT_OUT_EN.
module decim_polyphase_ctrl
  import decim_pkg::*;
#(
  parameter int NPH = NPH_DEF,
  parameter int DW  = DW_DEF,
  parameter int BW  = BW_DEF,
  parameter int LAT = LAT_DEF,
`ifdef DECIM_SAT_OUT_EN
  localparam int OW = BW
`else
  localparam int OW = sum_w(NPH, BW)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_sample,
  output logic              in_ready,
  output logic [NPH*DW-1:0] br_sample,
  output logic [NPH-1:0]    br_strobe,
  input  logic [NPH*BW-1:0] br_out,
  output logic              out_valid,
  output logic [OW-1:0]     out_data,
  input  logic              out_ready,
  output logic              busy,
  output state_e            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid holds its data until that edge, ready may change freely.
  localparam int PW = $clog2(NPH);
  localparam int CW = 4;

  state_e               state_q;
  logic [PW-1:0]        phase_q;
  logic [PW-1:0]        phase_d;
  logic [PW-1:0]        slot;
  logic [CW-1:0]        drain_q;
  logic [NPH*DW-1:0]    br_sample_q;
  logic [NPH-1:0]       br_strobe_q;
  logic                 out_valid_q;
  logic signed [OW-1:0] out_data_q;
  logic signed [OW-1:0] sum;
  logic                 accept;
  logic                 last_phase;

  decim_branch_sum #(
    .NPH (NPH),
    .BW  (BW),
    .OW  (OW)
  ) u_branch_sum (
    .br_i  (br_out),
    .sum_o (sum)
  );

  assign in_ready   = (state_q == COLLECT);
  assign accept     = in_valid && in_ready && !flush;
  assign last_phase = (phase_q == PW'(NPH-1));
  assign phase_d    = last_phase ? '0 : phase_q + 1'b1;
  // Newest sample goes to the lowest slice: phase 0 feeds branch NPH-1.
  assign slot       = PW'(NPH-1) - phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      phase_q     <= '0;
      drain_q     <= '0;
      br_sample_q <= '0;
      br_strobe_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      br_strobe_q <= '0;
      if (flush) begin
        state_q     <= COLLECT;
        phase_q     <= '0;
        drain_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          COLLECT: begin
            if (accept) begin
              br_sample_q[slot*DW +: DW] <= in_sample;
              br_strobe_q[slot]          <= 1'b1;
              phase_q                    <= phase_d;
              if (last_phase) begin
                state_q <= DRAIN;
                drain_q <= CW'(LAT);
              end
            end
          end
          DRAIN: begin
            if (drain_q == '0) begin
              out_data_q  <= sum;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              drain_q <= drain_q - 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              phase_q     <= '0;
              state_q     <= COLLECT;
            end
          end
          default: state_q <= COLLECT;
        endcase
      end
    end
  end

  assign br_sample   = br_sample_q;
  assign br_strobe   = br_strobe_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = !((state_q == COLLECT) && (phase_q == '0));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_decim_polyphase_ctrl.sv
// Directed bench for decim_polyphase_ctrl with NPH=4, DW=8, BW=17, LAT=4;
// expectations follow DECIM_SAT_OUT_EN when it is defined.
module tb_decim_polyphase_ctrl;
  import decim_pkg::*;

  localparam int NPH = 4;
  localparam int DW  = 8;
  localparam int BW  = 17;
  localparam int LAT = 4;
`ifdef DECIM_SAT_OUT_EN
  localparam int OW = BW;
`else
  localparam int OW = BW + 2;
`endif

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [DW-1:0]     in_sample;
  logic              in_ready;
  logic [NPH*DW-1:0] br_sample;
  logic [NPH-1:0]    br_strobe;
  logic [NPH*BW-1:0] br_out;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic              out_ready;
  logic              busy;
  state_e            dbg_state;

  logic [OW-1:0] exp_q[$];
  int n_total;
  int n_pass;

  decim_polyphase_ctrl #(
    .NPH (NPH),
    .DW  (DW),
    .BW  (BW),
    .LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .in_ready    (in_ready),
    .br_sample   (br_sample),
    .br_strobe   (br_strobe),
    .br_out      (br_out),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] slice(input int k);
    logic signed [DW-1:0] t;
    t = br_sample[k*DW +: DW];
    return 64'(t);
  endfunction

  function automatic logic signed [63:0] odata();
    logic signed [OW-1:0] t;
    t = out_data;
    return 64'(t);
  endfunction

  // Expected decimated result for branch outputs b0..b3.
  function automatic logic signed [63:0] model_sum(input longint b0, input longint b1,
                                                   input longint b2, input longint b3);
    longint s;
    s = b0 + b1 + b2 + b3;
`ifdef DECIM_SAT_OUT_EN
    if (s > 65535)  s = 65535;
    if (s < -65536) s = -65536;
`endif
    return 64'(s);
  endfunction

  task automatic set_br(input int b0, input int b1, input int b2, input int b3);
    br_out = {BW'(b3), BW'(b2), BW'(b1), BW'(b0)};
    exp_q.push_back(OW'(model_sum(b0, b1, b2, b3)));
  endtask

  task automatic send(input int v);
    in_valid  = 1'b1;
    in_sample = DW'(v);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  // Count edges from the last acceptance until out_valid rises.
  task automatic wait_out(input string tag);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    chk(tag, 64'(cnt), 64'(LAT + 1));
  endtask

  task automatic handshake(input string tag);
    logic [OW-1:0] e;
    logic signed [OW-1:0] es;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    es = e;
    chk(tag, odata(), 64'(es));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, 64'(out_valid), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 1);
  endtask

  initial begin
    int viol;
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b0;
    br_out    = '0;

    step();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", odata(), 0);
    chk("rst_br_sample", 64'(br_sample), 0);
    chk("rst_br_strobe", 64'(br_strobe), 0);
    chk("rst_busy", 64'(busy), 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 1);

    // Frame 1: samples 1..4 back to back, branch results 10,20,30,40
    set_br(10, 20, 30, 40);
    send(1);
    chk("f1_strobe0", 64'(br_strobe), 64'h8);
    chk("f1_busy", 64'(busy), 1);
    send(2); send(3); send(4);
    chk("f1_strobe3", 64'(br_strobe), 64'h1);
    chk("f1_drain_ready", 64'(in_ready), 0);
    chk("f1_state_drain", 64'(dbg_state), 64'(DRAIN));
    wait_out("f1_latency");
    chk("f1_state_hold", 64'(dbg_state), 64'(HOLD));

    // Back-pressure in HOLD with a sample on offer
    in_valid  = 1'b1;
    in_sample = DW'(99);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || odata() !== 100) viol++;
    end
    in_valid = 1'b0;
    chk("hold_stable", 64'(viol), 0);
    chk("hold_no_accept", slice(3), 1);
    handshake("f1_data");
    chk("f1_busy_idle", 64'(busy), 0);

    // Frame 2: 5,-6,7,-8 with idle gaps between samples
    set_br(-5, 100, 7, 1000);
    send(5);
    chk("f2_strobe_s3", 64'(br_strobe), 64'h8);
    step();
    chk("f2_gap_strobe", 64'(br_strobe), 0);
    chk("f2_gap_busy", 64'(busy), 1);
    send(-6);
    chk("f2_strobe_s2", 64'(br_strobe), 64'h4);
    step();
    send(7);
    chk("f2_strobe_s1", 64'(br_strobe), 64'h2);
    step();
    send(-8);
    chk("f2_strobe_s0", 64'(br_strobe), 64'h1);
    chk("f2_slice3", slice(3), 5);
    chk("f2_slice2", slice(2), -6);
    chk("f2_slice1", slice(1), 7);
    chk("f2_slice0", slice(0), -8);
    wait_out("f2_latency");
    handshake("f2_data");

    // Flush after two samples, with a third sample offered in the flush cycle
    send(11);
    send(22);
    in_valid  = 1'b1;
    in_sample = DW'(33);
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("fl_busy", 64'(busy), 0);
    chk("fl_strobe", 64'(br_strobe), 0);
    chk("fl_slice1_kept", slice(1), 7);
    chk("fl_slice2_kept", slice(2), 22);
    chk("fl_out_valid", 64'(out_valid), 0);
    set_br(1, 2, 3, 4);
    send4(9, 8, 7, 6);
    wait_out("fl_latency");
    handshake("fl_data");

    // Full-scale branch results
    set_br(65535, 65535, 65535, 65535);
    send4(1, 1, 1, 1);
    wait_out("max_latency");
    handshake("max_data");
    set_br(-65536, -65536, -65536, -65536);
    send4(2, 2, 2, 2);
    wait_out("min_latency");
    handshake("min_data");

    // Reset in the middle of DRAIN discards the frame
    br_out = '0;
    send4(3, 3, 3, 3);
    step();
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mrst_out_valid", 64'(out_valid), 0);
    chk("mrst_br_sample", 64'(br_sample), 0);
    chk("mrst_out_data", odata(), 0);
    chk("mrst_state", 64'(dbg_state), 64'(COLLECT));
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_in_ready", 64'(in_ready), 1);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b0) viol++;
    end
    chk("mrst_no_valid", 64'(viol), 0);

    set_br(-1, -2, 3, 5);
    send4(4, 4, 4, 4);
    wait_out("post_latency");
    handshake("post_data");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decim_polyphase_ctrl.md
DECIM_POLYPHASE_CTRL -- requirements
Module: decim_polyphase_ctrl

Interface
REQ-001 Parameter NPH, default 4, number of polyphase branches (decimation factor), legal 2..8.
REQ-002 Parameter DW, default 8, signed input sample width.
REQ-003 Parameter BW, default 17, signed branch-result width.
REQ-004 Parameter LAT, default 4, fixed branch pipeline latency in cycles, legal 1..15.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 flush  in  1  synchronous abort of current frame.
REQ-008 in_valid  in  1  input sample offered.
REQ-009 in_sample  in  DW  signed input sample.
REQ-010 in_ready  out  1  controller accepts sample this cycle.
REQ-011 br_sample  out  NPH*DW  per-branch held sample; slice k feeds branch k.
REQ-012 br_strobe  out  NPH  one-hot, one cycle, marks which branch slice was just loaded.
REQ-013 br_out  in  NPH*BW  signed branch results, slice k from branch k.
REQ-014 out_valid  out  1  decimated result available.
REQ-015 out_data  out  BW+clog2(NPH)  signed sum of all branch results.
REQ-016 out_ready  in  1  downstream accepts out_data.
REQ-017 busy  out  1  high in any state other than COLLECT with phase 0.

Function
REQ-018 Sample accepted when in_valid && in_ready; in_ready is high only in COLLECT.
REQ-019 Phase counter 0..NPH-1 selects commutator target; accepted sample registers into br_sample slice (NPH-1-phase), matching polyphase input ordering; br_strobe bit for that slice high next cycle.
REQ-020 Phase counter increments per accepted sample and wraps NPH-1 -> 0.
REQ-021 FSM states COLLECT, DRAIN, HOLD.
REQ-022 COLLECT -> DRAIN on acceptance at phase NPH-1; drain counter loads LAT.
REQ-023 DRAIN decrements per cycle; at 0 out_data captures sign-extended sum of all NPH br_out slices and FSM -> HOLD, out_valid high next cycle.
REQ-024 HOLD: out_valid and out_data stable until out_ready; on out_valid && out_ready -> COLLECT, phase 0, same cycle in_ready rises next cycle.
REQ-025 Latency: last frame sample accepted at cycle t -> out_valid at cycle t+LAT+1.
REQ-026 Exactly NPH accepted samples per out_valid pulse; no sample dropped or duplicated under any in_valid/out_ready pattern.
REQ-027 Sum width BW+clog2(NPH) is never overflowing; full-precision arithmetic.
REQ-028 flush in any state: phase to 0, drain counter 0, out_valid low, FSM to COLLECT next cycle; flush wins over simultaneous acceptance and output handshake; br_sample retained.
REQ-029 in_valid toggling between phases stalls the phase counter without corrupting held slices.

Reset
REQ-030 On rst_n low: FSM COLLECT, phase 0, drain counter 0, br_sample all 0, br_strobe 0, out_valid 0, out_data 0, busy 0; in_ready 1 after release.
REQ-031 Reset mid-DRAIN or mid-HOLD discards pending frame; no out_valid after release until NPH new samples plus LAT+1 cycles.

Configuration
REQ-032 Macro DECIM_SAT_OUT_EN defined: out_data width is BW, sum saturated to BW-bit signed min/max.
REQ-033 DECIM_SAT_OUT_EN undefined: out_data full width BW+clog2(NPH), no saturation logic compiled.

Structure
REQ-034 Shared package decim_pkg holds FSM state enum, NPH/DW/BW/LAT defaults and sum-width function.
REQ-035 One sub-module decim_branch_sum: combinational NPH-input signed adder tree with optional saturation; controller owns all registers.

Verification
REQ-036 Reset then samples 1,2,3,4 back-to-back, br_out slices fixed 10,20,30,40 -> out_data 100, out_valid exactly 5 cycles after 4th acceptance.
REQ-037 out_ready held low 10 cycles in HOLD -> in_ready low, out_data 100 stable, no extra acceptance; release -> one handshake, in_ready high next cycle.
REQ-038 Sample order 5,-6,7,-8 -> br_sample slices 3,2,1,0 hold 5,-6,7,-8 with matching one-hot br_strobe.
REQ-039 flush asserted after 2 samples -> phase 0, no out_valid; next 4 samples produce normal output.
REQ-040 br_out slices all +65535 (BW=17): with DECIM_SAT_OUT_EN out_data 65535; without, out_data 262140.
REQ-041 rst_n pulsed low mid-DRAIN -> out_valid stays 0, all outputs zero, in_ready 1 after release.
